// File: rtl/gslcd_v1_0_pixel_out.sv
`default_nettype none
// ==== gslcd_v1_0_pixel_out : locks an AXI4-Stream pixel source to LCD frame timing, drives the panel bus ====
// ==== Revision 1.0 ====
module gslcd_v1_0_pixel_out #(
  parameter int                       C_FRAME_WIDTH   = 800,
  parameter int                       C_PIXEL_WIDTH   = 24,
  parameter int                       C_COL_WIDTH     = 10,
  parameter logic [C_PIXEL_WIDTH-1:0] C_FILL_COLOR    = '0,
  parameter int                       C_ERR_CNT_WIDTH = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESETN,
  input  logic                       EN,
  input  logic                       VSYNC,
  input  logic                       HSYNC,
  input  logic                       ACTIVE,
  input  logic                       FRAME_START,
  input  logic [C_PIXEL_WIDTH-1:0]   S_PIXEL_TDATA,
  input  logic                       S_PIXEL_TVALID,
  output logic                       S_PIXEL_TREADY,
  input  logic                       S_PIXEL_TUSER,
  input  logic                       S_PIXEL_TLAST,
  output logic [C_PIXEL_WIDTH-1:0]   LCD_DATA,
  output logic                       LCD_VSYNC,
  output logic                       LCD_HSYNC,
  output logic                       LCD_DE,
  output logic                       LOCKED,
  output logic                       UNDERFLOW,
  output logic                       LINE_ERR,
  output logic [C_ERR_CNT_WIDTH-1:0] UNDERFLOW_CNT,
  input  logic                       CLR_ERR
);

  localparam logic [C_COL_WIDTH-1:0]     LAST_COL = C_COL_WIDTH'(C_FRAME_WIDTH - 1);
  localparam logic [C_COL_WIDTH-1:0]     COL_ONE  = C_COL_WIDTH'(1);
  localparam logic [C_ERR_CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [C_ERR_CNT_WIDTH-1:0] CNT_ONE  = C_ERR_CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t                 state;
  logic [C_COL_WIDTH-1:0] col;

  logic sof_pix;
  logic sof_ok;
  logic early_sof;
  logic late_sof;
  logic active_run;
  logic last_col;
  logic xfer;
  logic show_pix;
  logic underflow_evt;
  logic line_err_evt;

  always_comb begin
    sof_pix        = S_PIXEL_TVALID & S_PIXEL_TUSER;
    sof_ok         = FRAME_START & sof_pix;
    early_sof      = (state == RUN) & ~FRAME_START & sof_pix;
    late_sof       = (state == RUN) & FRAME_START & ~sof_pix;
    active_run     = EN & ACTIVE & (state == RUN);
    last_col       = (col == LAST_COL);
    S_PIXEL_TREADY = 1'b0;
    // While unlocked, non-SOF pixels are flushed and the SOF pixel is held for FRAME_START
    if (PRESETN && EN && ACTIVE) begin
      if (state == WAIT_SOF) S_PIXEL_TREADY = ~S_PIXEL_TUSER | sof_ok;
      else                   S_PIXEL_TREADY = ~early_sof & ~late_sof;
    end
    xfer          = S_PIXEL_TREADY & S_PIXEL_TVALID;
    show_pix      = xfer & ((state == RUN) | sof_ok);
    underflow_evt = active_run & ~S_PIXEL_TVALID & ~FRAME_START;
    line_err_evt  = active_run & (early_sof
                                  | (xfer & S_PIXEL_TLAST & ~last_col)
                                  | (last_col & ~(xfer & S_PIXEL_TLAST)));
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state  <= WAIT_SOF;
      col    <= '0;
      LOCKED <= 1'b0;
    end else if (!EN) begin
      state  <= WAIT_SOF;
      col    <= '0;
      LOCKED <= 1'b0;
    end else if (ACTIVE) begin
      case (state)
        WAIT_SOF: begin
          if (sof_ok) begin
            state  <= RUN;
            LOCKED <= 1'b1;
            col    <= COL_ONE;
          end
        end
        RUN: begin
          if (early_sof || late_sof) begin
            state  <= WAIT_SOF;
            LOCKED <= 1'b0;
            col    <= '0;
          end else if (FRAME_START) begin
            col <= COL_ONE;
          end else if (last_col) begin
            col <= '0;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: begin
          state  <= WAIT_SOF;
          LOCKED <= 1'b0;
          col    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      LCD_DATA      <= '0;
      LCD_VSYNC     <= 1'b0;
      LCD_HSYNC     <= 1'b0;
      LCD_DE        <= 1'b0;
      UNDERFLOW     <= 1'b0;
      LINE_ERR      <= 1'b0;
      UNDERFLOW_CNT <= '0;
    end else begin
      LCD_VSYNC <= VSYNC;
      LCD_HSYNC <= HSYNC;
      LCD_DE    <= EN & ACTIVE;
      if (!EN || !ACTIVE) LCD_DATA <= '0;
      else if (show_pix)  LCD_DATA <= S_PIXEL_TDATA;
      else                LCD_DATA <= C_FILL_COLOR;
      // A new error in the clearing cycle wins over the clear
      UNDERFLOW <= (UNDERFLOW & ~CLR_ERR) | underflow_evt;
      LINE_ERR  <= (LINE_ERR & ~CLR_ERR) | line_err_evt;
      if (CLR_ERR)
        UNDERFLOW_CNT <= underflow_evt ? CNT_ONE : '0;
      else if (underflow_evt && (UNDERFLOW_CNT != CNT_MAX))
        UNDERFLOW_CNT <= UNDERFLOW_CNT + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gslcd_v1_0_pixel_out.sv
`default_nettype none
// ==== tb_gslcd_v1_0_pixel_out : directed frames checked against a frame-level behavioural model ====
// ==== Revision 1.0 ====
module tb_gslcd_v1_0_pixel_out;

  localparam int          W       = 16;
  localparam int          V_ACT   = 6;
  localparam int          H_TOTAL = 22;
  localparam int          V_TOTAL = 8;
  localparam int          EW      = 3;
  localparam int          CNT_MAX = (1 << EW) - 1;
  localparam logic [23:0] FILL    = 24'h5A5A5A;

  typedef struct {
    logic [23:0] data;
    bit          sof;
    bit          eol;
  } pix_t;

  typedef struct {
    bit          locked;
    int          pos;
    logic [23:0] data;
    bit          vs;
    bit          hs;
    bit          de;
    bit          uf;
    bit          le;
    int          cnt;
  } mstate_t;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b1;
  logic          vsync  = 1'b0;
  logic          hsync  = 1'b0;
  logic          active = 1'b0;
  logic          fs     = 1'b0;
  logic [23:0]   tdata  = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          tuser  = 1'b0;
  logic          tlast  = 1'b0;
  logic [23:0]   lcd_data;
  logic          lcd_vs;
  logic          lcd_hs;
  logic          lcd_de;
  logic          locked;
  logic          uf;
  logic          le;
  logic [EW-1:0] cnt;
  logic          clr    = 1'b0;

  int      checks   = 0;
  int      failures = 0;
  int      consumed = 0;
  int      h, v, f;
  bit      init_rst = 1'b1;
  bit      go       = 1'b0;
  pix_t    q[$];
  mstate_t m;

  gslcd_v1_0_pixel_out #(
    .C_FRAME_WIDTH  (W),
    .C_PIXEL_WIDTH  (24),
    .C_COL_WIDTH    (5),
    .C_FILL_COLOR   (FILL),
    .C_ERR_CNT_WIDTH(EW)
  ) dut (
    .PCLK          (clk),
    .PRESETN       (rst_n),
    .EN            (en),
    .VSYNC         (vsync),
    .HSYNC         (hsync),
    .ACTIVE        (active),
    .FRAME_START   (fs),
    .S_PIXEL_TDATA (tdata),
    .S_PIXEL_TVALID(tvalid),
    .S_PIXEL_TREADY(tready),
    .S_PIXEL_TUSER (tuser),
    .S_PIXEL_TLAST (tlast),
    .LCD_DATA      (lcd_data),
    .LCD_VSYNC     (lcd_vs),
    .LCD_HSYNC     (lcd_hs),
    .LCD_DE        (lcd_de),
    .LOCKED        (locked),
    .UNDERFLOW     (uf),
    .LINE_ERR      (le),
    .UNDERFLOW_CNT (cnt),
    .CLR_ERR       (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame/line/column positions where the source has no pixel ready
  function automatic bit hole(int fr, int l, int c);
    return (fr == 2 && l == 2 && c >= 4 && c <= 6) ||
           (fr == 8 && l == 3 && c <= 8) ||
           (fr == 8 && l == 4 && c == 2);
  endfunction

  function automatic logic [23:0] pix(int fr, int l, int c);
    if (fr == 1 && l == 0 && c == 0) return 24'hABCDEF;
    return {8'(fr), 8'(l), 8'(c)};
  endfunction

  task automatic push_frame(int fr, int limit);
    int n = 0;
    for (int l = 0; l < V_ACT; l++)
      for (int c = 0; c < W; c++)
        if (!hole(fr, l, c) && n < limit) begin
          q.push_back('{data: pix(fr, l, c), sof: (l == 0 && c == 0),
                        eol: (fr == 3 && l == 1) ? (c == W - 2) : (c == W - 1)});
          n++;
        end
  endtask

  function automatic bit exp_ready(bit lk);
    if (!rst_n || !en || !active) return 1'b0;
    if (!lk) return !tuser || (fs && tvalid);
    if (fs) return tvalid && tuser;
    return !(tvalid && tuser);
  endfunction

  function automatic mstate_t model_next(mstate_t s);
    mstate_t n = s;
    bit act, acc, sof, u, e;
    act  = en && active;
    acc  = exp_ready(s.locked) && tvalid;
    sof  = tvalid && tuser;
    n.vs = vsync;
    n.hs = hsync;
    n.de = act;
    if (!act)                                 n.data = '0;
    else if (acc && (s.locked || (fs && tuser))) n.data = tdata;
    else                                      n.data = FILL;
    u = act && s.locked && !tvalid && !fs;
    e = act && s.locked && ((!fs && sof) || (acc && tlast && s.pos != W - 1) ||
                            (s.pos == W - 1 && !(acc && tlast)));
    if (!en) begin
      n.locked = 1'b0;
      n.pos    = 0;
    end else if (active) begin
      if (fs && sof) begin
        n.locked = 1'b1;
        n.pos    = 1;
      end else if (s.locked && (fs || sof)) begin
        n.locked = 1'b0;
        n.pos    = 0;
      end else if (s.locked) begin
        n.pos = (s.pos + 1) % W;
      end
    end
    n.uf = (s.uf && !clr) || u;
    n.le = (s.le && !clr) || e;
    if (clr)                       n.cnt = u ? 1 : 0;
    else if (u && s.cnt < CNT_MAX) n.cnt = s.cnt + 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_next(m);
  end

  always @(negedge clk) begin
    if (go) begin
      chk("tready", tready, exp_ready(m.locked));
      chk("lcd_data", lcd_data, m.data);
      chk("lcd_vsync", lcd_vs, m.vs);
      chk("lcd_hsync", lcd_hs, m.hs);
      chk("lcd_de", lcd_de, m.de);
      chk("locked", locked, m.locked);
      chk("underflow", uf, m.uf);
      chk("line_err", le, m.le);
      chk("underflow_cnt", cnt, m.cnt);
    end
  end

  task automatic apply();
    active = (h < W) && (v < V_ACT);
    fs     = active && h == 0 && v == 0;
    hsync  = (h >= 18 && h < 20);
    vsync  = (v == V_TOTAL - 1);
    en     = !(f == 6 && v == 2 && h >= 7 && h <= 9);
    rst_n  = !init_rst && !(f == 7 && v == 1 && (h == 3 || h == 4));
    clr    = (f == 2 && v == 6 && h == 0) || (f == 8 && v == 4 && h == 2);
    tvalid = (q.size() > 0) && !(active && hole(f, v, h));
    if (q.size() > 0) begin
      tdata = q[0].data;
      tuser = q[0].sof;
      tlast = q[0].eol;
    end else begin
      tdata = '0;
      tuser = 1'b0;
      tlast = 1'b0;
    end
  endtask

  task automatic tick();
    bit hs;
    @(negedge clk);
    hs = tvalid && tready;
    @(posedge clk);
    #1;
    if (hs) begin
      void'(q.pop_front());
      consumed++;
    end
    h++;
    if (h == H_TOTAL) begin
      h = 0;
      v++;
      if (v == V_TOTAL) begin
        v = 0;
        f++;
      end
    end
    apply();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    h = H_TOTAL - 1;
    v = 4;
    f = 0;
    for (int i = 0; i < 5; i++) q.push_back('{data: 24'hEE0000 + 24'(i), sof: 1'b0, eol: 1'b0});
    push_frame(1, 1000);
    push_frame(2, 1000);
    push_frame(3, 1000);
    push_frame(4, 53);
    push_frame(5, 1000);
    push_frame(6, 93);
    push_frame(7, 94);
    push_frame(8, 1000);
    apply();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_lcd_data", lcd_data, 0);
    chk("reset_lcd_de", lcd_de, 0);
    chk("reset_locked", locked, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_flags", {uf, le}, 0);
    chk("reset_tready", tready, 0);
    go = 1'b1;
    @(posedge clk);
    #1;
    init_rst = 1'b0;
    apply();
    while (!(f == 8 && v == V_TOTAL - 1)) begin
      tick();
      if (f == 0 && v == 5 && h == 1) begin
        chk("preroll_fill", lcd_data, FILL);
        chk("preroll_unlocked", locked, 0);
      end
      if (f == 1 && v == 0 && h == 0) chk("preroll_consumed", consumed, 5);
      if (f == 1 && v == 0 && h == 1) begin
        chk("sof_pixel_shown", lcd_data, 24'hABCDEF);
        chk("locked_first_pixel", locked, 1);
      end
      if (f == 1 && v == 6 && h == 0) begin
        chk("frame1_consumed", consumed, 101);
        chk("frame1_underflow", uf, 0);
        chk("frame1_line_err", le, 0);
      end
      if (f == 2 && v == 2 && h == 5) chk("underflow_fill", lcd_data, FILL);
      if (f == 2 && v == 2 && h == 8) begin
        chk("underflow_cnt3", cnt, 3);
        chk("underflow_locked", locked, 1);
        chk("underflow_flag", uf, 1);
      end
      if (f == 2 && v == 6 && h == 1) begin
        chk("clr_cnt", cnt, 0);
        chk("clr_flag", uf, 0);
      end
      if (f == 3 && v == 1 && h == 14) chk("short_line_before", le, 0);
      if (f == 3 && v == 1 && h == 15) begin
        chk("short_line_err", le, 1);
        chk("short_line_locked", locked, 1);
      end
      if (f == 4 && v == 3 && h == 6) begin
        chk("early_sof_unlock", locked, 0);
        chk("early_sof_fill", lcd_data, FILL);
        chk("early_sof_err", le, 1);
      end
      if (f == 5 && v == 0 && h == 1) begin
        chk("relock_pixel", lcd_data, pix(5, 0, 0));
        chk("relock_locked", locked, 1);
      end
      if (f == 6 && v == 2 && h == 7) begin
        chk("en_low_tready", tready, 0);
        chk("en_low_locked_same", locked, 1);
      end
      if (f == 6 && v == 2 && h == 8) begin
        chk("en_low_locked", locked, 0);
        chk("en_low_de", lcd_de, 0);
        chk("en_low_sticky", le, 1);
      end
      if (f == 7 && v == 0 && h == 1) chk("en_relock", locked, 1);
      if (f == 7 && v == 1 && h == 3) begin
        chk("rst_de", lcd_de, 0);
        chk("rst_locked", locked, 0);
        chk("rst_tready", tready, 0);
        chk("rst_line_err", le, 0);
      end
      if (f == 8 && v == 0 && h == 1) begin
        chk("rst_relock_pixel", lcd_data, pix(8, 0, 0));
        chk("rst_relock", locked, 1);
      end
      if (f == 8 && v == 3 && h == 10) chk("cnt_saturate", cnt, CNT_MAX);
      if (f == 8 && v == 4 && h == 3) begin
        chk("clr_with_uf_cnt", cnt, 1);
        chk("clr_with_uf_flag", uf, 1);
      end
    end
    chk("total_consumed", consumed, 712);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
